// File: rtl/ad_mux_ch_scheduler.sv
// Channel scan scheduler for the pipelined ad_mux channel selector.
//
// A sample tick (while enabled and with a non-empty mask) latches ch_mask and
// walks its set bits in ascending order, one channel per clock, on ch_sel.
// The sel_* framing tags are then delayed by LATENCY clocks onto out_* so they
// line up with the mux data_out stream.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enable        - allows sample_tick to start a scan
//   ch_mask       - channel enable mask, latched at scan start
//   sample_tick   - one-cycle scan request
//   ovf_clr       - clears overflow (a simultaneous set wins)
//   ch_sel        - mux channel select, holds its last value when idle
//   sel_valid/first/last - framing for the current ch_sel
//   out_valid/ch/first/last - framing delayed by LATENCY
//   busy          - a scan is in progress
//   overflow      - sticky, a tick arrived during a scan and was dropped
module ad_mux_ch_scheduler #(
  parameter int unsigned CH_CNT   = 64,
  parameter int unsigned LATENCY  = 2,
  localparam int unsigned CH_SEL_W = $clog2(CH_CNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CH_CNT-1:0]   ch_mask,
  input  logic                sample_tick,
  input  logic                ovf_clr,
  output logic [CH_SEL_W-1:0] ch_sel,
  output logic                sel_valid,
  output logic                sel_first,
  output logic                sel_last,
  output logic                out_valid,
  output logic [CH_SEL_W-1:0] out_ch,
  output logic                out_first,
  output logic                out_last,
  output logic                busy,
  output logic                overflow
);

  localparam int unsigned TagW = CH_SEL_W + 3;
  localparam logic [CH_CNT-1:0] MaskOne = CH_CNT'(1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e              state_q, state_d;
  logic [CH_CNT-1:0]   mask_q, mask_d;
  logic [CH_SEL_W-1:0] ch_sel_q, ch_sel_d;
  logic                sel_valid_q, sel_valid_d;
  logic                sel_first_q, sel_first_d;
  logic                sel_last_q, sel_last_d;
  logic                overflow_q, overflow_d;

  logic [CH_CNT-1:0]   src_mask;
  logic [CH_CNT-1:0]   cand_mask;
  logic [CH_SEL_W-1:0] next_ch;
  logic                next_last;

  // Index of the lowest set bit (0 when empty).
  function automatic logic [CH_SEL_W-1:0] lowest_set(input logic [CH_CNT-1:0] v);
    logic [CH_SEL_W-1:0] idx;
    idx = '0;
    for (int i = CH_CNT - 1; i >= 0; i--) begin
      if (v[i]) idx = CH_SEL_W'(i);
    end
    return idx;
  endfunction

  // Bits strictly above channel c; the shift-out at the top channel yields 0.
  function automatic logic [CH_CNT-1:0] above(input logic [CH_SEL_W-1:0] c);
    return ~(((MaskOne << c) << 1) - MaskOne);
  endfunction

  // The same encoder serves the scan start (on ch_mask) and the advance
  // (on mask_q above the current channel). Last is known one step ahead so
  // sel_last can be registered together with ch_sel.
  always_comb begin
    src_mask  = (state_q == StIdle) ? ch_mask : mask_q;
    cand_mask = (state_q == StIdle) ? ch_mask : (mask_q & above(ch_sel_q));
    next_ch   = lowest_set(cand_mask);
    next_last = ((src_mask & above(next_ch)) == '0);
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ch_sel_d    = ch_sel_q;
    sel_valid_d = 1'b0;
    sel_first_d = 1'b0;
    sel_last_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable && sample_tick && (|ch_mask)) begin
          state_d     = StScan;
          mask_d      = ch_mask;
          ch_sel_d    = next_ch;
          sel_valid_d = 1'b1;
          sel_first_d = 1'b1;
          sel_last_d  = next_last;
        end
      end
      StScan: begin
        if (sel_last_q) begin
          state_d = StIdle;
        end else begin
          ch_sel_d    = next_ch;
          sel_valid_d = 1'b1;
          sel_last_d  = next_last;
        end
      end
      default: state_d = StIdle;
    endcase

    // Set has priority over clear.
    if ((state_q == StScan) && sample_tick) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      ch_sel_q    <= '0;
      sel_valid_q <= 1'b0;
      sel_first_q <= 1'b0;
      sel_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ch_sel_q    <= ch_sel_d;
      sel_valid_q <= sel_valid_d;
      sel_first_q <= sel_first_d;
      sel_last_q  <= sel_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ch_sel    = ch_sel_q;
  assign sel_valid = sel_valid_q;
  assign sel_first = sel_first_q;
  assign sel_last  = sel_last_q;
  assign busy      = (state_q == StScan);
  assign overflow  = overflow_q;

  // Tag pipeline matching the mux latency.
  logic [TagW-1:0] tag_in;
  logic [TagW-1:0] tag_out;

  assign tag_in = {sel_valid_q, sel_first_q, sel_last_q, ch_sel_q};

  if (LATENCY == 0) begin : g_no_pipe
    assign tag_out = tag_in;
  end else begin : g_pipe
    logic [TagW-1:0] tag_q [LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      end else begin
        tag_q[0] <= tag_in;
        for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
    end

    assign tag_out = tag_q[LATENCY-1];
  end

  assign out_valid = tag_out[TagW-1];
  assign out_first = tag_out[TagW-2];
  assign out_last  = tag_out[TagW-3];
  assign out_ch    = tag_out[CH_SEL_W-1:0];

endmodule
